// File: rtl/memory_controller_interface_pkg.sv
// Request/response structs exchanged between the CPU ports and the memory responder.
package memory_controller_interface;
    import rapid_pkg::*;

    typedef struct packed {
        logic            valid;
        logic            write;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [3:0]      wstrb;
    } mci_request_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] rdata;
    } mci_response_t;

    localparam logic [3:0] MCI_WSTRB_ALL = 4'hF;
endpackage

// File: rtl/rapid_pkg.sv
// Core-wide configuration shared by the CPU and its memory-side models.
package rapid_pkg;
    localparam int XLEN = 32;
endpackage

// File: rtl/mci_rr_arbiter.sv
// Two-requester round-robin arbiter; the grant history only moves when the caller advances it.
module mci_rr_arbiter (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_grant
);
    logic last_grant;  // 0 = requester 0 granted last, 1 = requester 1

    always_comb begin
        // NOTE: o_grant gets a default before any branch so no path leaves it unassigned (no latch).
        o_grant = 2'b00;
        if (i_req[0] && i_req[1]) begin
            o_grant = last_grant ? 2'b01 : 2'b10;
        end else if (i_req[0]) begin
            o_grant = 2'b01;
        end else if (i_req[1]) begin
            o_grant = 2'b10;
        end
    end

    // NOTE: sequential state uses <= so every register updates from pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            last_grant <= 1'b1;
        end else if (i_advance && (o_grant != 2'b00)) begin
            last_grant <= o_grant[1];
        end
    end
endmodule

// File: rtl/mci_dual_port_responder.sv
// Memory responder serving instruction (port1) and data (port2) requests from one
// shared word memory behind a round-robin arbiter and a fixed-latency FSM.
module mci_dual_port_responder
    import rapid_pkg::*;
    import memory_controller_interface::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  mci_request_t  mem_req_port1,
    output mci_response_t mem_res_port1,
    input  mci_request_t  mem_req_port2,
    output mci_response_t mem_res_port2,
    output logic          o_busy
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY) + 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} rsp_state_e;

    rsp_state_e       state;
    logic [CNT_W-1:0] cnt;
    mci_request_t     lat_req;
    logic             lat_port;

    logic [1:0]       grant;
    logic             any_valid;
    logic             sel_port;
    mci_request_t     sel_req;
    mci_request_t     acc_req;
    logic             acc_port;
    logic             fire;
    logic             in_range;
    logic             mem_we;
    logic [IDX_W-1:0] idx;
    mci_response_t    rsp;
    logic             unused_bits;

    logic [XLEN-1:0]  mem [DEPTH];

    assign any_valid = mem_req_port1.valid | mem_req_port2.valid;

    mci_rr_arbiter u_arb (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_req     ({mem_req_port2.valid, mem_req_port1.valid}),
        .i_advance ((state == IDLE) && any_valid),
        .o_grant   (grant)
    );

    assign sel_port = grant[1];
    assign sel_req  = sel_port ? mem_req_port2 : mem_req_port1;

    // The access happens on the edge that enters RESP, so with LATENCY==1 the live
    // granted request is used directly instead of the not-yet-latched copy.
    always_comb begin
        acc_req  = lat_req;
        acc_port = lat_port;
        fire     = 1'b0;
        if (state == IDLE) begin
            acc_req  = sel_req;
            acc_port = sel_port;
            fire     = (LATENCY == 1) && any_valid;
        end else if (state == ACCESS) begin
            fire = (cnt == CNT_W'(1));
        end
    end

    assign idx      = acc_req.addr[IDX_W+1:2];
    assign in_range = (acc_req.addr[XLEN-1:IDX_W+2] == '0);
    assign mem_we   = fire && acc_req.write && in_range && i_reset_n;

    always_comb begin
        rsp.valid = 1'b1;
        rsp.rdata = '0;
        if (!acc_req.write && in_range) begin
            rsp.rdata = mem[idx];
        end
    end

    // NOTE: the memory array has no reset; clearing it would block RAM inference and contents stay as written.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int b = 0; b < XLEN / 8; b++) begin
                if (acc_req.wstrb[b]) begin
                    mem[idx][8*b +: 8] <= acc_req.wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            lat_req       <= '0;
            lat_port      <= 1'b0;
            mem_res_port1 <= '0;
            mem_res_port2 <= '0;
            o_busy        <= 1'b0;
        end else begin
            mem_res_port1 <= '0;
            mem_res_port2 <= '0;
            if (fire) begin
                if (acc_port) begin
                    mem_res_port2 <= rsp;
                end else begin
                    mem_res_port1 <= rsp;
                end
            end

            case (state)
                IDLE: begin
                    if (any_valid) begin
                        lat_req  <= sel_req;
                        lat_port <= sel_port;
                        cnt      <= CNT_W'(LATENCY - 1);
                        o_busy   <= 1'b1;
                        state    <= (LATENCY == 1) ? RESP : ACCESS;
                    end
                end
                ACCESS: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign unused_bits = ^{acc_req.valid, acc_req.addr[1:0], grant[0]};
endmodule

// File: tb/tb_mci_dual_port_responder.sv
// Directed scoreboard bench: a LATENCY=2 responder for most scenarios and a LATENCY=1 one for throughput.
module tb_mci_dual_port_responder;
    import rapid_pkg::*;
    import memory_controller_interface::*;

    localparam int DEPTH = 1024;

    typedef struct {
        bit              port;
        logic [XLEN-1:0] rdata;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          dut_sel;
    mci_request_t  req1, req2;
    mci_request_t  req1_a, req2_a, req1_b, req2_b;
    mci_response_t res1_a, res2_a, res1_b, res2_b;
    mci_response_t r1, r2;
    logic          busy_a, busy_b, busy;

    int            n_checks = 0;
    int            n_fail   = 0;
    exp_t          sb[$];
    bit [XLEN-1:0] model [int];

    always #5 clk = ~clk;

    assign req1_a = dut_sel ? '0 : req1;
    assign req2_a = dut_sel ? '0 : req2;
    assign req1_b = dut_sel ? req1 : '0;
    assign req2_b = dut_sel ? req2 : '0;
    assign r1     = dut_sel ? res1_b : res1_a;
    assign r2     = dut_sel ? res2_b : res2_a;
    assign busy   = dut_sel ? busy_b : busy_a;

    mci_dual_port_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut_a (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .mem_req_port1 (req1_a),
        .mem_res_port1 (res1_a),
        .mem_req_port2 (req2_a),
        .mem_res_port2 (res2_a),
        .o_busy        (busy_a)
    );

    mci_dual_port_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut_b (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .mem_req_port1 (req1_b),
        .mem_res_port1 (res1_b),
        .mem_req_port2 (req2_b),
        .mem_res_port2 (res2_b),
        .o_busy        (busy_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] exp_read(input logic [XLEN-1:0] addr);
        if (addr >= XLEN'(DEPTH * 4)) return '0;
        return model[int'(addr >> 2)];
    endfunction

    // Presents a request on one port and records the response it must produce.
    task automatic drive(input bit port, input bit wr, input logic [XLEN-1:0] addr,
                         input logic [XLEN-1:0] wdata, input logic [3:0] wstrb);
        mci_request_t rq;
        exp_t         e;
        rq = '{valid: 1'b1, write: wr, addr: addr, wdata: wdata, wstrb: wstrb};
        e.port  = port;
        e.rdata = wr ? '0 : exp_read(addr);
        if (wr && addr < XLEN'(DEPTH * 4)) begin
            int            w;
            bit [XLEN-1:0] word;
            w    = int'(addr >> 2);
            word = model.exists(w) ? model[w] : '0;
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) word[8*b +: 8] = wdata[8*b +: 8];
            end
            model[w] = word;
        end
        sb.push_back(e);
        if (port) req2 = rq;
        else      req1 = rq;
    endtask

    task automatic release_port(input bit port);
        if (port) req2 = '0;
        else      req1 = '0;
    endtask

    // Waits for the next response pulse on either port and scores it.
    task automatic wait_resp(output int cycles);
        exp_t e;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (!r1.valid && !r2.valid) begin
                check("quiet_res1", r1, '0);
                check("quiet_res2", r2, '0);
            end
        end while (!r1.valid && !r2.valid && cycles < 16);

        if (!r1.valid && !r2.valid) begin
            check("resp_timeout", 64'(r1.valid | r2.valid), 64'd1);
        end else if (sb.size() == 0) begin
            check("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            check("resp_port", 64'(r2.valid), 64'(e.port));
            check("resp_rdata", e.port ? r2.rdata : r1.rdata, e.rdata);
            check("other_port_zero", e.port ? r1 : r2, '0);
        end
    endtask

    task automatic txn(input bit port, input bit wr, input logic [XLEN-1:0] addr,
                       input logic [XLEN-1:0] wdata, input logic [3:0] wstrb, input int exp_lat);
        int c;
        drive(port, wr, addr, wdata, wstrb);
        wait_resp(c);
        if (exp_lat > 0) check("latency", 64'(c), 64'(exp_lat));
        release_port(port);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        dut_sel = 1'b0;
        req1    = '0;
        req2    = '0;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_res1", r1, '0);
        check("rst_res2", r2, '0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Preload through the ports.
        txn(0, 1, 'h0,  'h11110000, MCI_WSTRB_ALL, 2);
        txn(0, 1, 'h4,  'h22220001, MCI_WSTRB_ALL, 2);
        txn(1, 1, 'h8,  'h33330002, MCI_WSTRB_ALL, 2);
        txn(1, 1, 'hC,  'h44440003, MCI_WSTRB_ALL, 2);
        txn(0, 1, 'h10, 'hDEADBEEF, MCI_WSTRB_ALL, 2);
        txn(1, 1, 'h20, 'hAAAAAAAA, MCI_WSTRB_ALL, 2);

        // Basic read with latency check, then byte-lane merge.
        txn(0, 0, 'h10, '0, '0, 2);
        txn(1, 1, 'h20, 'h11223344, 4'b0101, 2);
        txn(1, 0, 'h20, '0, '0, 2);

        // Out-of-range read and dropped write; ends on a port2 grant.
        txn(0, 0, 'h1000, '0, '0, 2);
        txn(1, 1, 'h1000, 'hFFFFFFFF, MCI_WSTRB_ALL, 2);

        // Both ports kept valid for four grants: P1, P2, P1, P2.
        drive(0, 0, 'h0, '0, '0);
        drive(1, 0, 'h8, '0, '0);
        wait_resp(c);
        drive(0, 0, 'h4, '0, '0);
        wait_resp(c);
        drive(1, 0, 'hC, '0, '0);
        wait_resp(c);
        release_port(0);
        wait_resp(c);
        release_port(1);
        @(negedge clk);

        // Reset while a port1 write sits in ACCESS.
        req1 = '{valid: 1'b1, write: 1'b1, addr: 32'h10, wdata: 32'h55555555, wstrb: MCI_WSTRB_ALL};
        @(posedge clk);
        #2;
        check("busy_in_access", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_res1", r1, '0);
        check("abort_res2", r2, '0);
        check("abort_busy", 64'(busy), 64'd0);
        req1 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(0, 0, 'h10, '0, '0);
        drive(1, 0, 'h20, '0, '0);
        wait_resp(c);
        release_port(0);
        wait_resp(c);
        release_port(1);
        @(negedge clk);

        // LATENCY=1 responder: preload, then back-to-back reads on port1.
        dut_sel = 1'b1;
        model.delete();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            txn(1, 1, XLEN'(i * 4), XLEN'(32'hC0DE0000 + i), MCI_WSTRB_ALL, 1);
        end
        drive(0, 0, 'h0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            wait_resp(c);
            check("b2b_interval", 64'(c), (i == 0) ? 64'd1 : 64'd2);
            if (i < 3) drive(0, 0, XLEN'((i + 1) * 4), '0, '0);
            else       release_port(0);
        end
        @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
